// File: rtl/count_sequence_checker_pkg.sv
// Shared definitions for the counter-stream checker: FSM state encodings and
// the width of the consecutive-match run counter.
package count_sequence_checker_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_SYNCING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int GOOD_RUN_W = 4;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating tally with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples its inputs from the same clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequence_checker.sv
// Receive-side checker for a free-running up-count stream: locks after a run of
// +1 increments, then flags breaks and wraps and keeps saturating tallies.
module count_sequence_checker
    import count_sequence_checker_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected
);

    state_t                  state;
    logic [WIDTH-1:0]        last;
    logic [GOOD_RUN_W-1:0]   good_run;
    logic [WIDTH-1:0]        last_inc;
    logic [GOOD_RUN_W-1:0]   run_inc;
    logic                    match;
    logic                    err_inc;
    logic                    wrap_inc;

    // NOTE: every combinational output gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        last_inc = last + 1'b1;
        run_inc  = good_run + 1'b1;
        match    = (sample == last_inc);
        err_inc  = sample_valid && (state == ST_LOCKED) && !match;
        wrap_inc = sample_valid && (state == ST_LOCKED) && match && (sample == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_UNSYNC;
            last       <= '0;
            good_run   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            expected   <= '0;
        end else begin
            err_pulse  <= err_inc;
            wrap_pulse <= wrap_inc;
            if (sample_valid) begin
                last     <= sample;
                expected <= sample + 1'b1;
                case (state)
                    ST_UNSYNC: begin
                        good_run <= '0;
                        state    <= ST_SYNCING;
                    end
                    ST_SYNCING: begin
                        if (match) begin
                            good_run <= run_inc;
                            if (run_inc == GOOD_RUN_W'(LOCK_COUNT)) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Any break, including a stalled repeat, drops back to resync.
                        if (!match) begin
                            good_run <= '0;
                            state    <= ST_SYNCING;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        good_run <= '0;
                        state    <= ST_UNSYNC;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_count (
        .clk (clk),
        .rst (rst),
        .clr (clear_counts),
        .inc (err_inc),
        .q   (err_count)
    );

    sat_counter #(.W(CNT_W)) u_wrap_count (
        .clk (clk),
        .rst (rst),
        .clr (clear_counts),
        .inc (wrap_inc),
        .q   (wrap_count)
    );

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: a behavioural model pushes expected
// outputs to a scoreboard queue each cycle, popped and compared after the edge.
module tb_count_sequence_checker;

    localparam int WIDTH      = 4;
    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0] expected;

    count_sequence_checker #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clear_counts (clear_counts),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .wrap_pulse   (wrap_pulse),
        .err_count    (err_count),
        .wrap_count   (wrap_count),
        .expected     (expected)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             locked;
        logic             err_pulse;
        logic             wrap_pulse;
        logic [CNT_W-1:0] err_count;
        logic [CNT_W-1:0] wrap_count;
        logic [WIDTH-1:0] expected;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  val;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    obs_t      dut_obs;
    assign dut_obs = {locked, err_pulse, wrap_pulse, err_count, wrap_count, expected};

    // Reference model state (0 unsync, 1 syncing, 2 locked)
    int               m_state;
    logic [WIDTH-1:0] m_last;
    int               m_run;
    logic             m_err;
    logic             m_wrap;
    logic [CNT_W-1:0] m_errc;
    logic [CNT_W-1:0] m_wrapc;
    logic [WIDTH-1:0] m_exp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [WIDTH-1:0] s, input bit clr);
        logic [WIDTH-1:0] nxt;
        bit               is_match;
        if (r) begin
            m_state = 0; m_last = '0; m_run = 0; m_err = 0; m_wrap = 0;
            m_errc = '0; m_wrapc = '0; m_exp = '0;
        end else begin
            m_err = 0;
            m_wrap = 0;
            if (v) begin
                nxt = m_last + 4'd1;
                is_match = (s == nxt);
                case (m_state)
                    0: begin m_run = 0; m_state = 1; end
                    1: if (is_match) begin
                           m_run = m_run + 1;
                           if (m_run == LOCK_COUNT) m_state = 2;
                       end else m_run = 0;
                    default: if (is_match) begin
                           if (s == 4'd0) m_wrap = 1;
                       end else begin
                           m_err = 1; m_run = 0; m_state = 1;
                       end
                endcase
                m_last = s;
                m_exp  = s + 4'd1;
            end
            if (clr) m_errc = '0;
            else if (m_err && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
            if (clr) m_wrapc = '0;
            else if (m_wrap && m_wrapc != 8'hFF) m_wrapc = m_wrapc + 8'd1;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit v,
                        input logic [WIDTH-1:0] s, input bit clr);
        sb_entry_t e;
        rst = r; sample_valid = v; sample = s; clear_counts = clr;
        model_step(r, v, s, clr);
        e.tag = tag;
        e.val = {(m_state == 2), m_err, m_wrap, m_errc, m_wrapc, m_exp};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.tag, 32'(dut_obs), 32'(e.val));
        rst = 1'b0; sample_valid = 1'b0; clear_counts = 1'b0;
    endtask

    logic [WIDTH-1:0] cur;

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample = '0; clear_counts = 1'b0;
        m_state = 0; m_last = '0; m_run = 0; m_err = 0; m_wrap = 0;
        m_errc = '0; m_wrapc = '0; m_exp = '0;

        step("reset0", 1, 0, 4'd0, 0);
        step("reset1", 1, 0, 4'd0, 0);
        check("reset_outputs", 32'(dut_obs), 32'd0);

        // Lock from 5,6,7
        step("s5", 0, 1, 4'd5, 0);
        step("s6", 0, 1, 4'd6, 0);
        step("s7", 0, 1, 4'd7, 0);
        check("lock_after_7", 32'(locked), 32'd1);
        check("expected_8", 32'(expected), 32'd8);
        step("idle_hold", 0, 0, 4'd3, 0);
        check("idle_expected_holds", 32'(expected), 32'd8);

        // Run up to 14, then wrap via 15,0,1
        for (int i = 8; i <= 14; i++) step("run_to_14", 0, 1, 4'(i), 0);
        step("s15", 0, 1, 4'd15, 0);
        step("s0_wrap", 0, 1, 4'd0, 0);
        check("wrap_pulse_hi", 32'(wrap_pulse), 32'd1);
        check("wrap_count_1", 32'(wrap_count), 32'd1);
        step("s1_after_wrap", 0, 1, 4'd1, 0);
        check("wrap_pulse_lo", 32'(wrap_pulse), 32'd0);
        check("locked_through_wrap", 32'(locked), 32'd1);

        // Break at 3 -> 9, relock on 10,11
        step("s2", 0, 1, 4'd2, 0);
        step("s3", 0, 1, 4'd3, 0);
        step("s9_break", 0, 1, 4'd9, 0);
        check("break_err_pulse", 32'(err_pulse), 32'd1);
        check("break_err_count", 32'(err_count), 32'd1);
        check("break_unlocked", 32'(locked), 32'd0);
        step("s10", 0, 1, 4'd10, 0);
        step("s11_relock", 0, 1, 4'd11, 0);
        check("relock_after_11", 32'(locked), 32'd1);

        // Stall at 6, then mismatches while syncing
        for (int i = 12; i <= 22; i++) step("run_to_6", 0, 1, 4'(i), 0);
        step("s6_stall", 0, 1, 4'd6, 0);
        check("stall_err_pulse", 32'(err_pulse), 32'd1);
        check("stall_err_count", 32'(err_count), 32'd2);
        step("sync_2", 0, 1, 4'd2, 0);
        step("sync_9", 0, 1, 4'd9, 0);
        step("sync_4", 0, 1, 4'd4, 0);
        check("sync_errs_not_counted", 32'(err_count), 32'd2);
        step("s5_resync", 0, 1, 4'd5, 0);
        step("s6_resync", 0, 1, 4'd6, 0);

        // Saturate the error tally
        cur = 4'd6;
        for (int i = 0; i < 260; i++) begin
            step("sat_break", 0, 1, cur + 4'd5, 0);
            step("sat_m1", 0, 1, cur + 4'd6, 0);
            step("sat_m2", 0, 1, cur + 4'd7, 0);
            cur = cur + 4'd7;
        end
        check("err_count_saturated", 32'(err_count), 32'd255);
        check("locked_after_sat", 32'(locked), 32'd1);

        // Clear coincident with an error
        step("clr_with_err", 0, 1, cur + 4'd3, 1);
        check("clr_err_count_0", 32'(err_count), 32'd0);
        check("clr_err_pulse_1", 32'(err_pulse), 32'd1);
        check("clr_wrap_count_0", 32'(wrap_count), 32'd0);
        cur = cur + 4'd3;
        step("relock_a", 0, 1, cur + 4'd1, 0);
        step("relock_b", 0, 1, cur + 4'd2, 0);
        cur = cur + 4'd2;
        check("locked_before_rst", 32'(locked), 32'd1);

        // Reset coincident with a valid sample
        step("rst_with_valid", 1, 1, cur + 4'd1, 0);
        check("rst_outputs_zero", 32'(dut_obs), 32'd0);
        step("seed_9", 0, 1, 4'd9, 0);
        check("seed_not_locked", 32'(locked), 32'd0);
        check("seed_expected_10", 32'(expected), 32'd10);
        step("seed_10", 0, 1, 4'd10, 0);
        check("one_match_not_locked", 32'(locked), 32'd0);
        step("seed_11", 0, 1, 4'd11, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
